// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multi-cycle core's unified bus: one request at a time,
// serviced from a word array after LATENCY cycles, answered with a one-cycle Ready pulse.
module mc_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        WE,
  input  logic [31:0] Adr,
  input  logic [31:0] WD,
  input  logic [3:0]  ByteEn,
  output logic        Ready,
  output logic [31:0] RD,
  output logic        Err,
  output logic        Busy
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam bit          SingleCycle = (LATENCY == 1);
  localparam logic [3:0]  CntInit     = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
    $error("mc_mem_responder: LATENCY must be in 1..15");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("mc_mem_responder: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] wd_q;
  logic [3:0]  be_q;
  logic        ready_q;
  logic        busy_q;
  logic        err_q;
  logic [31:0] rd_q;

  logic [31:0] mem [DEPTH];

  logic          acc_we;
  logic [31:0]   acc_adr;
  logic [31:0]   acc_wd;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_idx;
  logic          acc_bad;
  logic          access;

  // With LATENCY=1 the access happens on the accept edge, so operands come straight
  // from the bus; otherwise they come from the holding registers.
  always_comb begin
    acc_we  = we_q;
    acc_adr = adr_q;
    acc_wd  = wd_q;
    acc_be  = be_q;
    if (state_q == StIdle) begin
      acc_we  = WE;
      acc_adr = Adr;
      acc_wd  = WD;
      acc_be  = ByteEn;
    end
    acc_idx = acc_adr[AW+1:2];
    acc_bad = (acc_adr[1:0] != 2'b00) || ((acc_adr >> (AW + 2)) != 32'd0);
    access  = !Reset && (((state_q == StIdle) && Req && SingleCycle) ||
                         ((state_q == StWait) && (cnt_q == 4'd0)));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      wd_q    <= 32'd0;
      be_q    <= 4'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Req) begin
            we_q   <= WE;
            adr_q  <= Adr;
            wd_q   <= WD;
            be_q   <= ByteEn;
            busy_q <= 1'b1;
            if (SingleCycle) begin
              state_q <= StResp;
              ready_q <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
      if (access) begin
        rd_q  <= acc_bad ? 32'd0 : mem[acc_idx];
        err_q <= acc_bad;
      end
    end
  end

  // Array is deliberately outside the reset domain: contents survive Reset.
  always_ff @(posedge Clk) begin
    if (access && acc_we && !acc_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
        end
      end
    end
  end

  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign RD    = rd_q;
  assign Err   = err_q;

endmodule
